// File: rtl/fir_decim_buffer_if.sv
// fir_decim_buffer_if: sample-in / FIFO-out handshake bundle for fir_decim_buffer
interface fir_decim_buffer_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  logic in_valid;
  logic [WIDTH-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out_data;
  logic [$clog2(DEPTH+1)-1:0] level;
  logic overflow;
  modport master (
    output in_valid, in_data, out_ready,
    input out_valid, out_data, level, overflow
  );
  modport slave (
    input in_valid, in_data, out_ready,
    output out_valid, out_data, level, overflow
  );
endinterface

// File: rtl/fir_decim_buffer.sv
// fir_decim_buffer: drops filter warm-up samples, decimates, and buffers kept samples in a FWFT FIFO
module fir_decim_buffer #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 299,
  parameter int DECIM  = 4,
  parameter int DEPTH  = 16
) (
  input logic clock,
  input logic reset,
  fir_decim_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int SW = SETTLE > 0 ? $clog2(SETTLE + 1) : 1;
  localparam int PW = DECIM > 1 ? $clog2(DECIM) : 1;
  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [0:0] INIT = SETTLE == 0 ? RUN : FILL;
  logic [0:0] state;
  logic [SW-1:0] settle_cnt;
  logic [PW-1:0] phase;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [LW-1:0] level;
  logic [WIDTH-1:0] head, head_next;
  logic overflow, keep, pop, full, push, drop;
  assign keep = state == RUN && bus.in_valid && phase == '0;
  assign pop  = level != '0 && bus.out_ready;
  assign full = level == LW'(DEPTH);
  assign push = keep && (!full || pop);
  assign drop = keep && full && !pop;
  // head bypasses the array when the kept sample lands in an empty (or emptying) FIFO
  always_comb begin
    head_next = push && (level == '0 || (pop && level == LW'(1))) ? bus.in_data :
                pop && level > LW'(1) ? mem[rd_ptr + AW'(1)] : head;
  end
  always_ff @(posedge clock) begin
    if (!reset && push) mem[wr_ptr] <= bus.in_data;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= INIT;
      settle_cnt <= '0;
      phase      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      head       <= '0;
      overflow   <= 1'b0;
    end else begin
      if (state == FILL && bus.in_valid) begin
        settle_cnt <= settle_cnt + SW'(1);
        if (settle_cnt == SW'(SETTLE - 1)) state <= RUN;
      end
      if (state == RUN && bus.in_valid) phase <= phase == PW'(DECIM - 1) ? '0 : phase + PW'(1);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push) - LW'(pop);
      head  <= head_next;
      if (drop) overflow <= 1'b1;
    end
  end
  assign bus.out_valid = level != '0;
  assign bus.out_data  = head;
  assign bus.level     = level;
  assign bus.overflow  = overflow;
endmodule

// File: tb/tb_fir_decim_buffer.sv
// tb_fir_decim_buffer: directed scenarios plus randomized traffic against a queue-based model
module tb_fir_decim_buffer;
  localparam int WIDTH = 8, SETTLE = 3, DECIM = 2, DEPTH = 4;
  localparam int LW = $clog2(DEPTH + 1);
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  fir_decim_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  fir_decim_buffer #(.WIDTH(WIDTH), .SETTLE(SETTLE), .DECIM(DECIM), .DEPTH(DEPTH))
    dut (.clock(clk), .reset(rst), .bus(bus));
  int checks = 0, passes = 0;
  logic [WIDTH-1:0] q[$];
  int m_cnt, m_ph;
  bit m_run, m_ovf;
  logic [WIDTH-1:0] m_out;
  typedef logic [WIDTH+LW+1:0] obs_t;
  function automatic obs_t pack(logic v, logic [WIDTH-1:0] d, logic [LW-1:0] l, logic o);
    return {v, d, l, o};
  endfunction
  task automatic step(input logic r, input logic v, input logic [WIDTH-1:0] d, input logic rdy);
    bit keep;
    rst = r; bus.in_valid = v; bus.in_data = d; bus.out_ready = rdy;
    @(posedge clk);
    keep = 0;
    if (r) begin
      q.delete(); m_cnt = 0; m_ph = 0; m_run = (SETTLE == 0); m_ovf = 0; m_out = '0;
    end else begin
      if (!m_run) begin
        if (v) begin m_cnt++; if (m_cnt == SETTLE) m_run = 1; end
      end else if (v) begin
        keep = (m_ph == 0); m_ph = (m_ph + 1) % DECIM;
      end
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (keep) begin
        if (q.size() < DEPTH) q.push_back(d); else m_ovf = 1;
      end
      if (q.size() != 0) m_out = q[0];
    end
    #1;
  endtask
  function automatic obs_t obs();
    return pack(bus.out_valid, bus.out_data, bus.level, bus.overflow);
  endfunction
  task automatic test_reset;
    step(1, 1, 8'h55, 1);
    step(0, 0, 0, 0);
    checks++;
    if (obs() !== pack(0, 0, 0, 0)) $display("FAIL reset got %h exp %h", obs(), pack(0, 0, 0, 0));
    else passes++;
  endtask
  task automatic test_settle;
    for (int i = 1; i <= 3; i++) begin
      step(0, 1, 8'(i), 0);
      checks++;
      if (bus.level !== 0) $display("FAIL settle_discard%0d got %0d exp 0", i, bus.level);
      else passes++;
    end
    step(0, 1, 4, 0);
    checks++;
    if (obs() !== pack(1, 4, 1, 0)) $display("FAIL settle_first got %h exp %h", obs(), pack(1, 4, 1, 0));
    else passes++;
    step(0, 1, 5, 0);
    step(0, 1, 6, 0);
    checks++;
    if (obs() !== pack(1, 4, 2, 0)) $display("FAIL decim_keep got %h exp %h", obs(), pack(1, 4, 2, 0));
    else passes++;
    step(0, 0, 0, 1);
    checks++;
    if (obs() !== pack(1, 6, 1, 0)) $display("FAIL pop_next got %h exp %h", obs(), pack(1, 6, 1, 0));
    else passes++;
    step(0, 0, 0, 1);
    checks++;
    if (obs() !== pack(0, 6, 0, 0)) $display("FAIL empty_hold got %h exp %h", obs(), pack(0, 6, 0, 0));
    else passes++;
  endtask
  task automatic test_gapped;
    logic [WIDTH-1:0] exp_seq [2] = '{8'hA1, 8'hC3};
    logic vs [7] = '{1, 1, 0, 1, 1, 0, 1};
    logic [WIDTH-1:0] ds [7] = '{8'h07, 8'hA1, 8'hEE, 8'hB2, 8'hC3, 8'hEE, 8'hD4};
    for (int i = 0; i < 7; i++) step(0, vs[i], ds[i], 0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs() !== pack(1, exp_seq[i], LW'(2 - i), 0))
        $display("FAIL gapped%0d got %h exp %h", i, obs(), pack(1, exp_seq[i], LW'(2 - i), 0));
      else passes++;
      step(0, 0, 0, 1);
    end
  endtask
  task automatic test_overflow;
    logic [WIDTH-1:0] exp_seq [4] = '{1, 3, 5, 7};
    for (int i = 1; i <= 8; i++) step(0, 1, 8'(i), 0);
    checks++;
    if (obs() !== pack(1, 1, 4, 0)) $display("FAIL full_no_ovf got %h exp %h", obs(), pack(1, 1, 4, 0));
    else passes++;
    step(0, 1, 9, 0);
    step(0, 1, 10, 0);
    checks++;
    if (obs() !== pack(1, 1, 4, 1)) $display("FAIL overflow got %h exp %h", obs(), pack(1, 1, 4, 1));
    else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.out_data !== exp_seq[i] || bus.out_valid !== 1'b1)
        $display("FAIL ovf_drain%0d got %0d exp %0d", i, bus.out_data, exp_seq[i]);
      else passes++;
      step(0, 0, 0, 1);
    end
    checks++;
    if (obs() !== pack(0, 7, 0, 1)) $display("FAIL ovf_sticky got %h exp %h", obs(), pack(0, 7, 0, 1));
    else passes++;
  endtask
  task automatic test_full_pop;
    logic [WIDTH-1:0] exp_seq [4] = '{13, 15, 17, 19};
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    for (int i = 11; i <= 18; i++) step(0, 1, 8'(i), 0);
    checks++;
    if (obs() !== pack(1, 11, 4, 0)) $display("FAIL refill got %h exp %h", obs(), pack(1, 11, 4, 0));
    else passes++;
    step(0, 1, 19, 1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs() !== pack(1, exp_seq[i], LW'(4 - i), 0))
        $display("FAIL full_pop%0d got %h exp %h", i, obs(), pack(1, exp_seq[i], LW'(4 - i), 0));
      else passes++;
      step(0, 0, 0, 1);
    end
  endtask
  task automatic test_reset_mid;
    for (int i = 21; i <= 26; i++) step(0, 1, 8'(i), 0);
    checks++;
    if (bus.level !== 3) $display("FAIL mid_level got %0d exp 3", bus.level);
    else passes++;
    step(1, 1, 8'h99, 1);
    checks++;
    if (obs() !== pack(0, 0, 0, 0)) $display("FAIL mid_reset got %h exp %h", obs(), pack(0, 0, 0, 0));
    else passes++;
    for (int i = 0; i < 3; i++) step(0, 1, 8'h77, 0);
    checks++;
    if (bus.level !== 0) $display("FAIL mid_resettle got %0d exp 0", bus.level);
    else passes++;
    step(0, 1, 50, 0);
    checks++;
    if (obs() !== pack(1, 50, 1, 0)) $display("FAIL mid_first got %h exp %h", obs(), pack(1, 50, 1, 0));
    else passes++;
  endtask
  task automatic test_random;
    obs_t exp_o;
    step(1, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0);
      exp_o = pack(q.size() != 0, m_out, LW'(q.size()), m_ovf);
      checks++;
      if (obs() !== exp_o) $display("FAIL random%0d got %h exp %h", n, obs(), exp_o);
      else passes++;
    end
  endtask
  initial begin
    bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0;
    test_reset;
    test_settle;
    test_gapped;
    test_overflow;
    test_full_pop;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
